// File: rtl/apple1_clk_rst_gen.sv
// -----------------------------------------------------------------------------
// apple1_clk_rst_gen
//
// Clock-enable and reset generator that sits between the board pins and the
// Apple 1 core.
//
// Everything runs on the 25 MHz system clock. The block does three jobs:
//   * It synchronises and debounces the raw reset push-button.
//   * It stretches every reset cause into a clean, registered active-low
//     system reset.
//   * It divides the system clock into a single-cycle CPU clock-enable pulse
//     and counts the pulses since the core left reset.
//
// Parameters:
//   CLK_DIV            clk25 cycles per cpu_ce pulse (1..65535)
//   DEBOUNCE_CYCLES    cycles the synchronised button must differ from the
//                      debounced level before that level flips (>=1)
//   RST_STRETCH        minimum cycles sys_rst_n stays low after a cause (>=1)
//   BUTTON_ACTIVE_HIGH 1 = pin high when pressed, 0 = pin low when pressed
//
// Ports:
//   clk25        in   system clock, all logic on its rising edge
//   rst_n        in   synchronous active-low board / power-on reset
//   button       in   raw asynchronous push-button pin
//   turbo        in   (only with APPLE1_CLK_RST_TURBO_EN) cpu_ce every cycle
//   sys_rst_n    out  registered active-low reset to the core
//   cpu_ce       out  registered single-cycle CPU clock enable
//   btn_pressed  out  debounced button level, 1 = pressed
//   cpu_ce_count out  16-bit count of cpu_ce pulses since sys_rst_n rose
//
// Optional feature macro: APPLE1_CLK_RST_TURBO_EN
//   When it is defined, a turbo input is added. While turbo is high and the
//   core is running, cpu_ce is high on every cycle and the divider is held at
//   zero.
// -----------------------------------------------------------------------------
module apple1_clk_rst_gen #(
  parameter int unsigned CLK_DIV            = 25,
  parameter int unsigned DEBOUNCE_CYCLES    = 250000,
  parameter int unsigned RST_STRETCH        = 16,
  parameter bit          BUTTON_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk25,
  input  logic        rst_n,
  input  logic        button,
`ifdef APPLE1_CLK_RST_TURBO_EN
  input  logic        turbo,
`endif
  output logic        sys_rst_n,
  output logic        cpu_ce,
  output logic        btn_pressed,
  output logic [15:0] cpu_ce_count
);

  // Counter widths: just enough bits for the largest value, never below 1 bit.
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DBC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned STR_W = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(RST_STRETCH - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_BTNHELD = 2'd2
  } state_t;

  // Button path
  logic             btn_norm_s;
  logic             sync1_q;
  logic             sync2_q;
  logic [DBC_W-1:0] deb_cnt_q;
  logic [DBC_W-1:0] deb_cnt_d;
  logic             btn_pressed_q;
  logic             btn_pressed_d;

  // Reset sequencer
  state_t           state_q;
  logic [STR_W-1:0] stretch_q;
  logic             sys_rst_n_q;
  logic             sys_rst_n_d;

  // CPU enable path
  logic             run_s;
  logic             turbo_s;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             cpu_ce_q;
  logic             cpu_ce_d;
  logic [15:0]      ce_count_q;
  logic [15:0]      ce_count_d;

  // Normalise the pin so that 1 always means pressed.
  assign btn_norm_s = BUTTON_ACTIVE_HIGH ? button : ~button;

`ifdef APPLE1_CLK_RST_TURBO_EN
  assign turbo_s = turbo;
`else
  assign turbo_s = 1'b0;
`endif

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_norm_s;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: count consecutive disagreeing cycles and flip the
  // level on the last one. Any agreement restarts the count, so a shorter
  // glitch has no effect.
  always_comb begin
    deb_cnt_d     = deb_cnt_q;
    btn_pressed_d = btn_pressed_q;
    if (sync2_q == btn_pressed_q) begin
      deb_cnt_d = DBC_W'(0);
    end else if (deb_cnt_q == DBC_LAST) begin
      deb_cnt_d     = DBC_W'(0);
      btn_pressed_d = ~btn_pressed_q;
    end else begin
      deb_cnt_d = deb_cnt_q + DBC_W'(1);
    end
  end

  // Debounce registers.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      deb_cnt_q     <= DBC_W'(0);
      btn_pressed_q <= 1'b0;
    end else begin
      deb_cnt_q     <= deb_cnt_d;
      btn_pressed_q <= btn_pressed_d;
    end
  end

  // Next value of the registered reset output. The divider and pulse counter
  // also use it, so that they clear on the same edge that sys_rst_n falls.
  always_comb begin
    sys_rst_n_d = 1'b0;
    case (state_q)
      ST_HOLD: begin
        if (stretch_q == STR_LAST) begin
          sys_rst_n_d = ~btn_pressed_q;
        end else begin
          sys_rst_n_d = 1'b0;
        end
      end
      ST_RUN:     sys_rst_n_d = ~btn_pressed_q;
      ST_BTNHELD: sys_rst_n_d = 1'b0;
      default:    sys_rst_n_d = 1'b0;
    endcase
  end

  // Reset sequencer. HOLD stretches every reset cause. BTNHELD waits for the
  // debounced release, then goes back through HOLD so that the release is
  // stretched too. A press that arrives during HOLD is honoured when the
  // stretch ends.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      stretch_q   <= STR_W'(0);
      sys_rst_n_q <= 1'b0;
    end else begin
      sys_rst_n_q <= sys_rst_n_d;
      case (state_q)
        ST_HOLD: begin
          if (stretch_q == STR_LAST) begin
            stretch_q <= STR_W'(0);
            if (btn_pressed_q) begin
              state_q <= ST_BTNHELD;
            end else begin
              state_q <= ST_RUN;
            end
          end else begin
            stretch_q <= stretch_q + STR_W'(1);
          end
        end
        ST_RUN: begin
          if (btn_pressed_q) begin
            state_q <= ST_BTNHELD;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_BTNHELD: begin
          if (!btn_pressed_q) begin
            state_q   <= ST_HOLD;
            stretch_q <= STR_W'(0);
          end else begin
            state_q <= ST_BTNHELD;
          end
        end
        default: begin
          state_q   <= ST_HOLD;
          stretch_q <= STR_W'(0);
        end
      endcase
    end
  end

  // The divider only advances when the core was running and keeps running.
  // The edge on which sys_rst_n rises therefore leaves the divider at zero.
  // This places the first pulse exactly CLK_DIV edges after that rise.
  assign run_s = sys_rst_n_q & sys_rst_n_d;

  // Divider next state. cpu_ce is registered from the terminal count, so it
  // is high for one cycle each time the divider wraps.
  always_comb begin
    div_d    = DIV_W'(0);
    cpu_ce_d = 1'b0;
    if (!run_s) begin
      div_d    = DIV_W'(0);
      cpu_ce_d = 1'b0;
    end else if (turbo_s) begin
      div_d    = DIV_W'(0);
      cpu_ce_d = 1'b1;
    end else if (div_q == DIV_LAST) begin
      div_d    = DIV_W'(0);
      cpu_ce_d = 1'b1;
    end else begin
      div_d    = div_q + DIV_W'(1);
      cpu_ce_d = 1'b0;
    end
  end

  // Pulse counter next state. It wraps naturally at 16 bits.
  always_comb begin
    ce_count_d = ce_count_q;
    if (!sys_rst_n_d) begin
      ce_count_d = 16'd0;
    end else if (cpu_ce_q) begin
      ce_count_d = ce_count_q + 16'd1;
    end else begin
      ce_count_d = ce_count_q;
    end
  end

  // Divider, enable pulse and pulse counter registers.
  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      div_q      <= DIV_W'(0);
      cpu_ce_q   <= 1'b0;
      ce_count_q <= 16'd0;
    end else begin
      div_q      <= div_d;
      cpu_ce_q   <= cpu_ce_d;
      ce_count_q <= ce_count_d;
    end
  end

  assign sys_rst_n    = sys_rst_n_q;
  assign cpu_ce       = cpu_ce_q;
  assign btn_pressed  = btn_pressed_q;
  assign cpu_ce_count = ce_count_q;

endmodule

// File: tb/tb_apple1_clk_rst_gen.sv
// Self-checking bench for apple1_clk_rst_gen with CLK_DIV=4, DEBOUNCE_CYCLES=8,
// RST_STRETCH=5 and an active-high button. The variable cyc holds the number
// of rising edges seen so far. Expected cpu_ce pulse edges are queued by the
// stimulus and consumed by a monitor on the falling edge.
module tb_apple1_clk_rst_gen;
  localparam int CLK_DIV = 4;
  localparam int DEB     = 8;
  localparam int STR     = 5;

  logic        clk25 = 1'b0;
  logic        rst_n;
  logic        button;
`ifdef APPLE1_CLK_RST_TURBO_EN
  logic        turbo;
`endif
  logic        sys_rst_n;
  logic        cpu_ce;
  logic        btn_pressed;
  logic [15:0] cpu_ce_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_q[$];
  int next_pulse;

  typedef struct {
    logic rst_n;
    logic button;
    int   n;
    int   exp_sys;
    int   exp_btn;
    int   exp_ce;
    int   exp_cnt;
  } vec_t;
  vec_t vecs[8];

  apple1_clk_rst_gen #(
    .CLK_DIV(CLK_DIV),
    .DEBOUNCE_CYCLES(DEB),
    .RST_STRETCH(STR),
    .BUTTON_ACTIVE_HIGH(1'b1)
  ) dut (
    .clk25(clk25),
    .rst_n(rst_n),
    .button(button),
`ifdef APPLE1_CLK_RST_TURBO_EN
    .turbo(turbo),
`endif
    .sys_rst_n(sys_rst_n),
    .cpu_ce(cpu_ce),
    .btn_pressed(btn_pressed),
    .cpu_ce_count(cpu_ce_count)
  );

  always #20 clk25 = ~clk25;

  always @(posedge clk25) cyc <= cyc + 1;

  // Scoreboard monitor: every cpu_ce pulse must match the head of the queue.
  always @(negedge clk25) begin
    while (exp_q.size() > 0 && exp_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL pulse_missing: got no cpu_ce at edge %0d, expected one", exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (cpu_ce === 1'b1) begin
      checks++;
      if (exp_q.size() > 0 && exp_q[0] == cyc) begin
        void'(exp_q.pop_front());
      end else begin
        errors++;
        $display("FAIL pulse_unexpected: got cpu_ce=1 at edge %0d, expected 0", cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic push_until(input int lim);
    while (next_pulse <= lim) begin
      exp_q.push_back(next_pulse);
      next_pulse += CLK_DIV;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at edge %0d, expected finish", cyc);
    $fatal(1);
  end

  initial begin
    int press_e;
    int fall_e;
    int rise;
    int last_fall;
    int t0;
    logic prev_b;

    // Power-on, cadence and glitch rejection as a vector table.
    vecs[0] = '{1'b0, 1'b0, 3,  0, 0, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 4,  0, 0, 0, 0};
    vecs[2] = '{1'b1, 1'b0, 1,  1, 0, 0, 0};
    vecs[3] = '{1'b1, 1'b0, 4,  1, 0, 1, 0};
    vecs[4] = '{1'b1, 1'b0, 1,  1, 0, 0, 1};
    vecs[5] = '{1'b1, 1'b0, 8,  1, 0, 0, 3};
    vecs[6] = '{1'b1, 1'b1, 7,  1, 0, 1, 4};
    vecs[7] = '{1'b1, 1'b0, 12, 1, 0, 1, 7};

    rst_n  = 1'b0;
    button = 1'b0;
`ifdef APPLE1_CLK_RST_TURBO_EN
    turbo  = 1'b0;
`endif
    // rst_n first seen high at edge 4, so sys_rst_n rises at edge 8.
    next_pulse = 8 + CLK_DIV;
    push_until(40);

    for (int i = 0; i < 8; i++) begin
      rst_n  = vecs[i].rst_n;
      button = vecs[i].button;
      wait_edges(vecs[i].n);
      check($sformatf("vec%0d_sys_rst_n", i), 32'(sys_rst_n), 32'(vecs[i].exp_sys));
      check($sformatf("vec%0d_btn_pressed", i), 32'(btn_pressed), 32'(vecs[i].exp_btn));
      check($sformatf("vec%0d_cpu_ce", i), 32'(cpu_ce), 32'(vecs[i].exp_ce));
      check($sformatf("vec%0d_count", i), 32'(cpu_ce_count), 32'(vecs[i].exp_cnt));
    end

    // Clean press held for 30 cycles, then a clean release.
    button  = 1'b1;
    press_e = cyc + 1;
    fall_e  = press_e + 2 + DEB;
    push_until(fall_e - 1);
    wait_edges(fall_e - 1 - cyc);
    check("press_before_sys", 32'(sys_rst_n), 32'd1);
    check("press_btn_pressed", 32'(btn_pressed), 32'd1);
    wait_edges(1);
    check("press_sys_low", 32'(sys_rst_n), 32'd0);
    check("press_ce_low", 32'(cpu_ce), 32'd0);
    check("press_count_clr", 32'(cpu_ce_count), 32'd0);
    while (cyc < press_e + 29) begin
      wait_edges(1);
      check("held_sys_low", 32'(sys_rst_n), 32'd0);
      check("held_count_clr", 32'(cpu_ce_count), 32'd0);
    end
    button = 1'b0;
    rise   = cyc + 1 + 2 + DEB + STR;
    while (cyc < rise - 1) begin
      wait_edges(1);
      check("release_sys_low", 32'(sys_rst_n), 32'd0);
    end
    wait_edges(1);
    check("release_sys_high", 32'(sys_rst_n), 32'd1);
    next_pulse = rise + CLK_DIV;

    // Press again, then let the release bounce before it settles.
    push_until(cyc + 10);
    wait_edges(10);
    button  = 1'b1;
    press_e = cyc + 1;
    fall_e  = press_e + 2 + DEB;
    push_until(fall_e - 1);
    wait_edges(fall_e - cyc);
    check("press2_sys_low", 32'(sys_rst_n), 32'd0);
    wait_edges(3);
    prev_b    = 1'b1;
    last_fall = 0;
    for (int i = 0; i < 20; i++) begin
      button = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
      if (prev_b && !button) last_fall = cyc + 1;
      prev_b = button;
      wait_edges(1);
      check("bounce_sys_low", 32'(sys_rst_n), 32'd0);
      check("bounce_btn_held", 32'(btn_pressed), 32'd1);
    end
    rise = last_fall + 2 + DEB + STR;
    while (cyc < rise - 1) begin
      wait_edges(1);
      check("settle_sys_low", 32'(sys_rst_n), 32'd0);
    end
    wait_edges(1);
    check("settle_sys_high", 32'(sys_rst_n), 32'd1);
    next_pulse = rise + CLK_DIV;

    // Board reset while the divider is at 2: the pending pulse must not appear.
    push_until(next_pulse + CLK_DIV);
    wait_edges(next_pulse - 2 - cyc);
    rst_n = 1'b0;
    wait_edges(1);
    check("midrst_sys_low", 32'(sys_rst_n), 32'd0);
    check("midrst_ce_low", 32'(cpu_ce), 32'd0);
    check("midrst_count_clr", 32'(cpu_ce_count), 32'd0);
    rst_n      = 1'b1;
    rise       = cyc + STR;
    next_pulse = rise + CLK_DIV;
    wait_edges(rise - 1 - cyc);
    check("midrst_sys_still_low", 32'(sys_rst_n), 32'd0);
    wait_edges(1);
    check("midrst_sys_high", 32'(sys_rst_n), 32'd1);
    push_until(rise + 10);
    wait_edges(rise + 10 - cyc);
    check("midrst_count", 32'(cpu_ce_count), 32'd2);

`ifdef APPLE1_CLK_RST_TURBO_EN
    // Turbo for 10 cycles: one pulse per cycle, then normal cadence resumes.
    turbo = 1'b1;
    t0    = cyc + 1;
    for (int k = 0; k < 10; k++) exp_q.push_back(t0 + k);
    for (int k = 0; k < 10; k++) begin
      wait_edges(1);
      check("turbo_count", 32'(cpu_ce_count), 32'(2 + k));
    end
    turbo      = 1'b0;
    next_pulse = t0 + 9 + CLK_DIV;
    push_until(cyc + 12);
    wait_edges(12);
    check("post_turbo_count", 32'(cpu_ce_count), 32'd14);
`else
    t0 = 0;
    push_until(cyc + 8);
    wait_edges(8);
    check("final_count", 32'(cpu_ce_count), 32'd4);
`endif

    @(negedge clk25);
    #1;
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
